// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings:
// lock inputs and restart strobe in, reset lines and status out.
interface pll_reset_sequencer_if;
  logic       sw_restart;
  logic       phi_locked;
  logic       theta_locked;
  logic       phi_pll_reset;
  logic       theta_pll_reset;
  logic       tdc_reset;
  logic       done;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  modport master (
    output sw_restart, phi_locked, theta_locked,
    input  phi_pll_reset, theta_pll_reset, tdc_reset, done, fault, state, lock_loss_cnt
  );

  modport slave (
    input  sw_restart, phi_locked, theta_locked,
    output phi_pll_reset, theta_pll_reset, tdc_reset, done, fault, state, lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Releases phi PLL, theta PLL and TDC resets in dependency order, gated on
// filtered PLL lock, with timeout/retry, lock-loss recovery and software restart.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_FILTER     = 4,
  parameter int unsigned LOCK_TIMEOUT    = 65535,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned CW              = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pll_reset_sequencer_if.slave   bus
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    PHI_RST    = 3'd0,
    PHI_WAIT   = 3'd1,
    THETA_RST  = 3'd2,
    THETA_WAIT = 3'd3,
    TDC_RST    = 3'd4,
    RUN        = 3'd5,
    FAULT      = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic [FW-1:0]  filt_q, filt_d;
  logic [RW-1:0]  phi_retry_q, phi_retry_d;
  logic [RW-1:0]  theta_retry_q, theta_retry_d;
  logic [LW-1:0]  loss_q, loss_d;
  logic           phi_meta_q, phi_sync_q;
  logic           theta_meta_q, theta_sync_q;
  logic           phi_rst_q, phi_rst_d;
  logic           theta_rst_q, theta_rst_d;
  logic           tdc_rst_q, tdc_rst_d;
  logic           done_q, done_d;
  logic           fault_q, fault_d;

  logic           hold_end;
  logic           timeout;
  logic           lock_sel;
  logic           qualify;

  // Two-flop synchronizers for the asynchronous lock indications
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phi_meta_q   <= 1'b0;
      phi_sync_q   <= 1'b0;
      theta_meta_q <= 1'b0;
      theta_sync_q <= 1'b0;
    end else begin
      phi_meta_q   <= bus.phi_locked;
      phi_sync_q   <= phi_meta_q;
      theta_meta_q <= bus.theta_locked;
      theta_sync_q <= theta_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PHI_RST;
      hold_q        <= '0;
      filt_q        <= '0;
      phi_retry_q   <= '0;
      theta_retry_q <= '0;
      loss_q        <= '0;
      phi_rst_q     <= 1'b1;
      theta_rst_q   <= 1'b1;
      tdc_rst_q     <= 1'b1;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      filt_q        <= filt_d;
      phi_retry_q   <= phi_retry_d;
      theta_retry_q <= theta_retry_d;
      loss_q        <= loss_d;
      phi_rst_q     <= phi_rst_d;
      theta_rst_q   <= theta_rst_d;
      tdc_rst_q     <= tdc_rst_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  // hold_q doubles as the reset-hold counter and the lock-wait timeout counter
  always_comb begin
    state_d       = state_q;
    hold_d        = '0;
    filt_d        = '0;
    phi_retry_d   = phi_retry_q;
    theta_retry_d = theta_retry_q;
    loss_d        = loss_q;
    phi_rst_d     = 1'b1;
    theta_rst_d   = 1'b1;
    tdc_rst_d     = 1'b1;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    hold_end      = (hold_q == CW'(RST_HOLD_CYCLES - 1));
    timeout       = (hold_q == CW'(LOCK_TIMEOUT - 1));
    lock_sel      = (state_q == THETA_WAIT) ? theta_sync_q : phi_sync_q;
    qualify       = lock_sel && (filt_q == FW'(LOCK_FILTER - 1));

    unique case (state_q)
      PHI_RST: begin
        if (hold_end) state_d = PHI_WAIT;
        else          hold_d  = hold_q + CW'(1);
      end
      PHI_WAIT: begin
        filt_d = lock_sel ? filt_q + FW'(1) : '0;
        if (qualify) begin
          state_d     = THETA_RST;
          phi_retry_d = '0;
        end else if (timeout) begin
          phi_retry_d = phi_retry_q + RW'(1);
          state_d     = (phi_retry_d > RW'(MAX_RETRIES)) ? FAULT : PHI_RST;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      THETA_RST: begin
        if (!phi_sync_q)   state_d = PHI_RST;
        else if (hold_end) state_d = THETA_WAIT;
        else               hold_d  = hold_q + CW'(1);
      end
      THETA_WAIT: begin
        filt_d = lock_sel ? filt_q + FW'(1) : '0;
        if (!phi_sync_q) begin
          state_d = PHI_RST;
        end else if (qualify) begin
          state_d       = TDC_RST;
          theta_retry_d = '0;
        end else if (timeout) begin
          theta_retry_d = theta_retry_q + RW'(1);
          state_d       = (theta_retry_d > RW'(MAX_RETRIES)) ? FAULT : THETA_RST;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      TDC_RST: begin
        if (!phi_sync_q)   state_d = PHI_RST;
        else if (hold_end) state_d = RUN;
        else               hold_d  = hold_q + CW'(1);
      end
      RUN: begin
        if (!phi_sync_q || !theta_sync_q) begin
          state_d = phi_sync_q ? THETA_RST : PHI_RST;
          if (loss_q != '1) loss_d = loss_q + LW'(1);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = PHI_RST;
    endcase

    // Software restart overrides every other transition
    if (bus.sw_restart) begin
      state_d       = PHI_RST;
      hold_d        = '0;
      filt_d        = '0;
      phi_retry_d   = '0;
      theta_retry_d = '0;
      loss_d        = loss_q;
    end

    unique case (state_d)
      PHI_WAIT:   phi_rst_d = 1'b0;
      THETA_RST:  phi_rst_d = 1'b0;
      THETA_WAIT: begin
        phi_rst_d   = 1'b0;
        theta_rst_d = 1'b0;
      end
      TDC_RST: begin
        phi_rst_d   = 1'b0;
        theta_rst_d = 1'b0;
      end
      RUN: begin
        phi_rst_d   = 1'b0;
        theta_rst_d = 1'b0;
        tdc_rst_d   = 1'b0;
        done_d      = 1'b1;
      end
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.phi_pll_reset   = phi_rst_q;
  assign bus.theta_pll_reset = theta_rst_q;
  assign bus.tdc_reset       = tdc_rst_q;
  assign bus.done            = done_q;
  assign bus.fault           = fault_q;
  assign bus.state           = 3'(state_q);
  assign bus.lock_loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short hold/filter/timeout values.
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pll_reset_sequencer_if bus_if ();

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_FILTER    (3),
    .LOCK_TIMEOUT   (20),
    .MAX_RETRIES    (2),
    .CW             (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // {phi_pll_reset, theta_pll_reset, tdc_reset, done, fault}
  function automatic logic [4:0] outs();
    return {bus_if.phi_pll_reset, bus_if.theta_pll_reset, bus_if.tdc_reset,
            bus_if.done, bus_if.fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until state matches; n = -1 if the budget expires
  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (bus_if.state !== s && n < budget) begin
      tick();
      n++;
    end
    if (bus_if.state !== s) n = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.sw_restart = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    bus_if.sw_restart   = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus_if.state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus_if.state);
    end
    checks++;
    if (outs() !== 5'b11100) begin
      errors++; $display("FAIL reset_outs: got %b want 11100", outs());
    end
    checks++;
    if (bus_if.lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_loss: got %0d want 0", bus_if.lock_loss_cnt);
    end
  endtask

  task automatic test_bringup();
    int n;
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    do_reset();
    wait_state(3'd1, 50, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bring_phi_wait_cycles: got %0d want 4", n); end
    checks++;
    if (outs() !== 5'b01100) begin errors++; $display("FAIL bring_phi_wait_outs: got %b want 01100", outs()); end
    repeat (6) tick();
    bus_if.phi_locked = 1'b1;
    wait_state(3'd2, 50, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL bring_theta_rst_cycles: got %0d want 5", n); end
    checks++;
    if (outs() !== 5'b01100) begin errors++; $display("FAIL bring_theta_rst_outs: got %b want 01100", outs()); end
    wait_state(3'd3, 50, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bring_theta_wait_cycles: got %0d want 4", n); end
    checks++;
    if (outs() !== 5'b00100) begin errors++; $display("FAIL bring_theta_wait_outs: got %b want 00100", outs()); end
    repeat (6) tick();
    bus_if.theta_locked = 1'b1;
    wait_state(3'd4, 50, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL bring_tdc_rst_cycles: got %0d want 5", n); end
    wait_state(3'd5, 50, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bring_run_cycles: got %0d want 4", n); end
    checks++;
    if (outs() !== 5'b00010) begin errors++; $display("FAIL bring_run_outs: got %b want 00010", outs()); end
  endtask

  task automatic test_glitch();
    int n;
    logic seq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    do_reset();
    wait_state(3'd1, 50, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL glitch_phi_wait_cycles: got %0d want 4", n); end
    for (int j = 0; j < 6; j++) begin
      bus_if.phi_locked = seq[j];
      tick();
    end
    checks++;
    if (bus_if.state !== 3'd1) begin errors++; $display("FAIL glitch_hold_a: got %0d want 1", bus_if.state); end
    tick();
    checks++;
    if (bus_if.state !== 3'd1) begin errors++; $display("FAIL glitch_hold_b: got %0d want 1", bus_if.state); end
    tick();
    checks++;
    if (bus_if.state !== 3'd2) begin errors++; $display("FAIL glitch_qualify: got %0d want 2", bus_if.state); end
  endtask

  task automatic test_no_lock();
    int n;
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_state(3'd1, 50, n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL nolock_wait_entry%0d: got %0d want 4", i, n); end
      wait_state((i < 2) ? 3'd0 : 3'd6, 50, n);
      checks++;
      if (n !== 20) begin errors++; $display("FAIL nolock_timeout%0d: got %0d want 20", i, n); end
    end
    checks++;
    if (outs() !== 5'b11101) begin errors++; $display("FAIL nolock_fault_outs: got %b want 11101", outs()); end
    repeat (10) tick();
    checks++;
    if (bus_if.state !== 3'd6) begin errors++; $display("FAIL nolock_sticky: got %0d want 6", bus_if.state); end
    bus_if.sw_restart = 1'b1;
    tick();
    bus_if.sw_restart = 1'b0;
    checks++;
    if (bus_if.state !== 3'd0) begin errors++; $display("FAIL nolock_restart_state: got %0d want 0", bus_if.state); end
    checks++;
    if (outs() !== 5'b11100) begin errors++; $display("FAIL nolock_restart_outs: got %b want 11100", outs()); end
    wait_state(3'd1, 50, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL nolock_restart_hold: got %0d want 4", n); end
    wait_state(3'd0, 50, n);
    checks++;
    if (n !== 20) begin errors++; $display("FAIL nolock_retry_cleared: got %0d want 20", n); end
  endtask

  task automatic test_theta_loss();
    int n;
    bus_if.phi_locked   = 1'b1;
    bus_if.theta_locked = 1'b1;
    do_reset();
    wait_state(3'd5, 100, n);
    checks++;
    if (n !== 18) begin errors++; $display("FAIL tloss_bringup: got %0d want 18", n); end
    bus_if.theta_locked = 1'b0;
    tick();
    bus_if.theta_locked = 1'b1;
    wait_state(3'd2, 20, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL tloss_detect: got %0d want 2", n); end
    checks++;
    if (outs() !== 5'b01100) begin errors++; $display("FAIL tloss_outs: got %b want 01100", outs()); end
    checks++;
    if (bus_if.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL tloss_count: got %0d want 1", bus_if.lock_loss_cnt); end
    wait_state(3'd5, 50, n);
    checks++;
    if (n !== 11) begin errors++; $display("FAIL tloss_requalify: got %0d want 11", n); end
    checks++;
    if (outs() !== 5'b00010) begin errors++; $display("FAIL tloss_run_outs: got %b want 00010", outs()); end
  endtask

  task automatic test_simul_loss();
    int n;
    int lost;
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    tick();
    bus_if.phi_locked   = 1'b1;
    bus_if.theta_locked = 1'b1;
    wait_state(3'd0, 20, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL simul_detect: got %0d want 2", n); end
    checks++;
    if (bus_if.lock_loss_cnt !== 8'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", bus_if.lock_loss_cnt); end
    checks++;
    if (outs() !== 5'b11100) begin errors++; $display("FAIL simul_outs: got %b want 11100", outs()); end
    wait_state(3'd5, 100, n);
    checks++;
    if (n !== 18) begin errors++; $display("FAIL simul_requalify: got %0d want 18", n); end
    lost = 0;
    for (int i = 0; i < 300; i++) begin
      bus_if.phi_locked = 1'b0;
      tick();
      bus_if.phi_locked = 1'b1;
      wait_state(3'd0, 20, n);
      if (n < 0) lost++;
      wait_state(3'd5, 100, n);
      if (n < 0) lost++;
    end
    checks++;
    if (lost !== 0) begin errors++; $display("FAIL simul_loop_waits: got %0d expired want 0", lost); end
    checks++;
    if (bus_if.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL simul_saturate: got %0d want 255", bus_if.lock_loss_cnt); end
  endtask

  task automatic test_restart_priority();
    int n;
    bus_if.theta_locked = 1'b0;
    tick();
    bus_if.theta_locked = 1'b1;
    wait_state(3'd3, 30, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL prio_theta_wait: got %0d want 6", n); end
    repeat (2) tick();
    bus_if.sw_restart = 1'b1;
    tick();
    bus_if.sw_restart = 1'b0;
    checks++;
    if (bus_if.state !== 3'd0) begin errors++; $display("FAIL prio_restart_wins: got %0d want 0", bus_if.state); end
    checks++;
    if (bus_if.lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL prio_loss_kept: got %0d want 255", bus_if.lock_loss_cnt); end
    checks++;
    if (outs() !== 5'b11100) begin errors++; $display("FAIL prio_restart_outs: got %b want 11100", outs()); end
    wait_state(3'd4, 50, n);
    checks++;
    if (n !== 14) begin errors++; $display("FAIL prio_tdc_rst: got %0d want 14", n); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 5'b11100) begin errors++; $display("FAIL async_reset_outs: got %b want 11100", outs()); end
    checks++;
    if (bus_if.state !== 3'd0 || bus_if.lock_loss_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset_state: got state %0d loss %0d want 0 0", bus_if.state, bus_if.lock_loss_cnt);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_if.sw_restart   = 1'b0;
    bus_if.phi_locked   = 1'b0;
    bus_if.theta_locked = 1'b0;
    test_reset();
    test_bringup();
    test_glitch();
    test_no_lock();
    test_theta_loss();
    test_simul_loss();
    test_restart_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Hardware reset sequencer for the TDC sensor clocking chain. It owns the phi PLL, theta PLL and TDC reset lines and releases them in dependency order: phi PLL, then theta PLL, then TDC. Releases are gated on qualified PLL lock, with timeout/retry and run-time lock-loss recovery. It sits between the PLL lock outputs, a software restart strobe from a PIO, and the reset inputs of the PLLs and TDC.

Parameters:
RST_HOLD_CYCLES, 16, cycles each reset is held asserted in a *_RST state (>=1)
LOCK_FILTER, 4, consecutive synchronized-locked cycles required to qualify lock (>=1)
LOCK_TIMEOUT, 65535, cycles allowed in a *_WAIT state before timeout (<2^CW)
MAX_RETRIES, 3, timeouts tolerated per stage before FAULT
CW, 16, width of internal hold/timeout counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
sw_restart  in  1  single-cycle software restart request (clk domain)
phi_locked  in  1  phi PLL locked, asynchronous
theta_locked  in  1  theta PLL locked, asynchronous
phi_pll_reset  out  1  phi PLL reset, active-high
theta_pll_reset  out  1  theta PLL reset, active-high
tdc_reset  out  1  TDC reset, active-high
done  out  1  chain up, all resets released
fault  out  1  retries exhausted
state  out  3  current FSM state encoding
lock_loss_cnt  out  8  saturating count of run-time lock losses

Behaviour:
- Reset values: phi_pll_reset=1, theta_pll_reset=1, tdc_reset=1, done=0, fault=0, state=PHI_RST(0), lock_loss_cnt=0, all counters and synchronizers 0.
- phi_locked and theta_locked each pass through a 2-FF synchronizer (2-cycle latency). All logic uses the synchronized versions.
- Outputs are registered Moore decodes and change in the same cycle the state register changes.
- State encodings: PHI_RST=0, PHI_WAIT=1, THETA_RST=2, THETA_WAIT=3, TDC_RST=4, RUN=5, FAULT=6.
- Output decode:
  - PHI_RST: phi, theta and tdc resets all 1.
  - PHI_WAIT: phi=0; theta and tdc resets 1.
  - THETA_RST and THETA_WAIT: phi=0, tdc=1; theta=1 in THETA_RST, 0 in THETA_WAIT.
  - TDC_RST: tdc=1, others 0.
  - RUN: all resets 0, done=1.
  - FAULT: all resets 1, fault=1.
- *_RST states: hold counter counts 0..RST_HOLD_CYCLES-1. The state is left after exactly RST_HOLD_CYCLES cycles. PHI_RST → PHI_WAIT, THETA_RST → THETA_WAIT, TDC_RST → RUN.
- *_WAIT states: the filter counter increments while the synchronized lock is 1 and clears to 0 when it is 0. When it reaches LOCK_FILTER, transition: PHI_WAIT → THETA_RST, THETA_WAIT → TDC_RST. The stage retry count clears on a qualified lock.
- Timeout: the timeout counter starts at 0 on WAIT entry. If it reaches LOCK_TIMEOUT-1 without qualified lock:
  - retry count increments;
  - if the new count <= MAX_RETRIES, return to the stage's *_RST state;
  - otherwise go to FAULT.
  - If lock qualification and timeout occur in the same cycle, lock wins.
- RUN lock loss:
  - Synchronized phi_locked=0 → PHI_RST.
  - Else synchronized theta_locked=0 → THETA_RST.
  - Either case increments lock_loss_cnt, saturating at 255.
  - Both low in the same cycle → PHI_RST, single increment.
  - done drops in the transition cycle.
- During THETA_RST, THETA_WAIT or TDC_RST, synchronized phi_locked=0 → PHI_RST (no lock_loss_cnt increment).
- sw_restart=1 in any state, including FAULT and mid-hold, → PHI_RST next cycle. It clears retry counts, the fault flag and all counters, but not lock_loss_cnt. sw_restart has priority over every other transition.
- FAULT is sticky; only sw_restart or reset leaves it.
- Asynchronous reset mid-sequence immediately forces all reset outputs to 1 and the state to PHI_RST.

Test Plan:
Bench parameters for all scenarios: RST_HOLD_CYCLES=4, LOCK_FILTER=3, LOCK_TIMEOUT=20, MAX_RETRIES=2.
1. Clean bring-up. Release reset at cycle 0; phi_locked rises at cycle 10; theta_locked rises 6 cycles after theta_pll_reset falls.
   → phi_pll_reset falls at cycle 4; theta_pll_reset rises-hold ends 4 cycles after THETA_RST entry; tdc_reset falls exactly 4 cycles after TDC_RST entry; done=1 with state=5.
2. Lock glitch. phi_locked toggles 1,1,0,1,1,1 in PHI_WAIT → filter restarts; transition to THETA_RST only after 3 consecutive synchronized highs.
3. Phi never locks. → 3 entries into PHI_WAIT, each exiting after 20 cycles; then state=6, fault=1, all resets=1. A later sw_restart pulse → state=0, fault=0.
4. Run-time loss, theta only. theta_locked drops for 1 cycle in RUN → state=THETA_RST, phi_pll_reset stays 0, tdc_reset=1, lock_loss_cnt=1, done=0; re-qualification returns to RUN.
5. Simultaneous loss. Both locks drop the same cycle in RUN → state=PHI_RST, lock_loss_cnt increments by exactly 1. Repeat 300 losses → lock_loss_cnt=255.
6. Restart priority. sw_restart asserted in the same cycle a lock qualifies in THETA_WAIT → PHI_RST, not TDC_RST. Asserting reset during TDC_RST → all resets 1 asynchronously, before the next clk edge.
